fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, maximum in-flight imem requests.
REQ-003 SHALL have parameter IQ_DEPTH, default 4, instruction queue entries (>= MAX_OUTSTANDING).
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port: clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port: fetch_en  in  1  permit new fetches.
REQ-008 SHALL have port: redirect_valid  in  1  one-cycle PC redirect (branch/exception).
REQ-009 SHALL have port: redirect_pc  in  32  new fetch PC.
REQ-010 SHALL have port: imem_req_valid  out  1  request to imem.
REQ-011 SHALL have port: imem_req_ready  in  1  imem can accept.
REQ-012 SHALL have port: imem_req_addr  out  32  byte address, always equal to pc_q.
REQ-013 SHALL have port: imem_resp_valid  in  1  imem response present.
REQ-014 SHALL have port: imem_resp_ready  out  1  tied 1 after reset.
REQ-015 SHALL have port: imem_resp_inst  in  32  instruction word.
REQ-016 SHALL have port: inst_valid  out  1  instruction to decode.
REQ-017 SHALL have port: inst_ready  in  1  decode accepts.
REQ-018 SHALL have port: inst_pc  out  32  PC of presented instruction.
REQ-019 SHALL have port: inst_data  out  32  presented instruction.
REQ-020 SHALL have port: busy  out  1  state!=IDLE or outstanding!=0 or IQ non-empty.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, DRAIN; IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0.
REQ-022 SHALL assert imem_req_valid only when state=RUN, fetch_en=1, redirect_valid=0, outstanding<MAX_OUTSTANDING and outstanding+iq_count<IQ_DEPTH (credit rule).
REQ-023 SHALL on request fire: pc_q <= pc_q+4 (mod 2^32 wrap), push pc_q into PC-tag FIFO, outstanding+1.
REQ-024 SHALL on response fire: pop PC-tag FIFO, outstanding-1; if drop_cnt=0 push {tag_pc, imem_resp_inst} into IQ, else discard and drop_cnt-1.
REQ-025 SHALL apply simultaneous request and response fire as net-zero outstanding change.
REQ-026 SHALL never overflow IQ; credit rule guarantees space, so imem_resp_ready stays 1.
REQ-027 SHALL drive inst_valid = IQ non-empty and redirect_valid=0; inst_pc/inst_data from IQ head; pop on inst_valid&&inst_ready.
REQ-028 SHALL make a response accepted in cycle t visible on inst_valid at t+1 (when IQ otherwise empty).
REQ-029 SHALL on redirect_valid (any state): pc_q <= redirect_pc; flush IQ; drop_cnt <= outstanding minus 1 if a response fires that cycle (that response discarded); no request issued that cycle.
REQ-030 SHALL enter DRAIN after redirect if drop_cnt_next>0, else RUN (fetch_en=1) or IDLE; DRAIN->RUN/IDLE when drop_cnt reaches 0.
REQ-031 SHALL in DRAIN issue no requests; a further redirect in DRAIN reloads pc_q and drop_cnt per REQ-029.
REQ-032 SHALL in IDLE still accept and enqueue responses of outstanding requests.
REQ-033 SHALL size outstanding and drop_cnt to $clog2(MAX_OUTSTANDING+1) bits.

Reset
REQ-034 SHALL on rst_n=0 set state=IDLE, pc_q=RESET_PC, outstanding=0, drop_cnt=0, both FIFOs empty.
REQ-035 SHALL hold imem_req_valid=0, inst_valid=0, busy=0, imem_resp_ready=0 during reset; any in-flight imem transaction is discarded (imem reset together).

Structure
REQ-036 SHALL place FSM state enum, fetch-entry struct {pc, inst} and default RESET_PC in shared package fetch_pkg.
REQ-037 SHALL use one sub-module fetch_fifo (parameterized sync FIFO with synchronous flush, count output), instantiated for PC-tag FIFO and IQ.

Verification
REQ-038 SHALL test: reset, fetch_en=1, imem latency 1, inst_ready=1 -> addresses 0,4,8,... issued back-to-back; inst_pc/inst_data match hex image in order.
REQ-039 SHALL test: inst_ready=0 -> exactly IQ_DEPTH=4 requests issued, then req_valid=0; release -> 4 instructions PCs 0..C, fetch resumes at 0x10.
REQ-040 SHALL test: redirect to 0x100 with 3 outstanding -> 3 responses dropped, state DRAIN 3 responses, next inst_pc=0x100.
REQ-041 SHALL test: redirect in same cycle as response fire with 2 outstanding -> that response discarded, drop_cnt=1, no stale instruction reaches decode.
REQ-042 SHALL test: pc_q=0xFFFF_FFFC fetch -> next imem_req_addr=0x0000_0000.
REQ-043 SHALL test: rst_n asserted mid-stream with 4 outstanding -> all outputs zero immediately, after release fetch restarts at RESET_PC with busy=0 until fetch_en.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM states, queue entry layout
// and the default reset fetch address.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterized synchronous FIFO with synchronous flush and occupancy count.
// Storage is not reset; only pointers and count are.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues sequential imem requests under a credit rule,
// tags responses with their PC and queues them for decode; redirects drop stale responses.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          IQ_DEPTH        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    output logic        imem_resp_ready,
    input  logic [31:0] imem_resp_inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        busy
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = $clog2(IQ_DEPTH + 1);
    localparam int TW = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_cnt_q, drop_cnt_d;
    logic          resp_ready_q;

    logic          req_fire;
    logic          resp_fire;
    logic          credit_ok;
    logic          iq_push;
    logic          iq_pop;
    logic          iq_empty;
    logic          iq_full;
    logic [QW-1:0] iq_count;
    fetch_entry_t  iq_head;
    fetch_entry_t  iq_in;
    logic [31:0]   tag_pc;
    logic          tag_empty;
    logic          tag_full;
    logic [TW-1:0] tag_count;
    logic          status_unused;

    // Requests are only issued when both an imem slot and a guaranteed IQ slot exist,
    // which is what lets imem_resp_ready stay high.
    assign credit_ok = (int'(outstanding_q) < MAX_OUTSTANDING) &&
                       (int'(outstanding_q) + int'(iq_count) < IQ_DEPTH);

    assign imem_req_valid  = (state_q == RUN) && fetch_en && !redirect_valid && credit_ok;
    assign imem_req_addr   = pc_q;
    assign imem_resp_ready = resp_ready_q;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign resp_fire       = imem_resp_valid && imem_resp_ready;

    assign iq_push    = resp_fire && (drop_cnt_q == '0) && !redirect_valid;
    assign inst_valid = !iq_empty && !redirect_valid;
    assign iq_pop     = inst_valid && inst_ready;
    assign inst_pc    = iq_head.pc;
    assign inst_data  = iq_head.inst;
    assign iq_in      = '{pc: tag_pc, inst: imem_resp_inst};

    assign busy = (state_q != IDLE) || (outstanding_q != '0) || !iq_empty;

    assign status_unused = ^{tag_empty, tag_full, tag_count, iq_full};

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (resp_fire),
        .pop_data  (tag_pc),
        .empty     (tag_empty),
        .full      (tag_full),
        .count     (tag_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (iq_push),
        .push_data (iq_in),
        .pop       (iq_pop),
        .pop_data  (iq_head),
        .empty     (iq_empty),
        .full      (iq_full),
        .count     (iq_count)
    );

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        state_d       = state_q;

        case ({req_fire, resp_fire})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_valid) begin
            // No request fires under redirect, so everything still in flight is stale.
            pc_d       = redirect_pc;
            drop_cnt_d = outstanding_d;
            if (drop_cnt_d != '0) state_d = DRAIN;
            else                  state_d = fetch_en ? RUN : IDLE;
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            if (resp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OW'(1);
            case (state_q)
                IDLE:    if (fetch_en) state_d = RUN;
                RUN:     if (!fetch_en) state_d = IDLE;
                DRAIN:   if (drop_cnt_d == '0) state_d = fetch_en ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            resp_ready_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            resp_ready_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an in-order, latency-1 imem model and a
// decode-side recorder; expected values are hand-computed constants.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic        imem_resp_ready;
    logic [31:0] imem_resp_inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] issued[$];
    logic [31:0] dec_pc[$];
    logic [31:0] dec_data[$];
    logic [31:0] pend[$];
    logic        resp_enable;

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_inst_valid;
    logic        s_busy;
    logic        s_resp_fire;

    logic [31:0] image [8] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193,
                               32'h0040_0213, 32'h0050_0293, 32'h0060_0313, 32'h0070_0393};

    fetch_ctrl #(
        .RESET_PC        (32'h0000_0000),
        .MAX_OUTSTANDING (4),
        .IQ_DEPTH        (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_ready (imem_resp_ready),
        .imem_resp_inst  (imem_resp_inst),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_pc         (inst_pc),
        .inst_data       (inst_data),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        if (addr < 32'h20) return image[addr[4:2]];
        return ~addr;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One call = N clock cycles, entered and left at a falling edge; handshakes are
    // sampled 1ns after the falling edge, the imem model advances after the next one.
    task automatic applyStimulus(input int cycles);
        logic        req_f;
        logic [31:0] req_a;
        for (int c = 0; c < cycles; c++) begin
            if (resp_enable && pend.size() > 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_inst  = inst_of(pend[0]);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_inst  = 32'h0;
            end
            #1;
            s_req_valid  = imem_req_valid;
            s_req_addr   = imem_req_addr;
            s_inst_valid = inst_valid;
            s_busy       = busy;
            s_resp_fire  = imem_resp_valid && imem_resp_ready;
            req_f        = imem_req_valid && imem_req_ready;
            req_a        = imem_req_addr;
            if (req_f) issued.push_back(req_a);
            if (inst_valid && inst_ready) begin
                dec_pc.push_back(inst_pc);
                dec_data.push_back(inst_data);
            end
            @(negedge clk);
            if (s_resp_fire) void'(pend.pop_front());
            if (req_f) pend.push_back(req_a);
        end
    endtask

    task automatic doReset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        resp_enable    = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_inst  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        pend.delete();
        issued.delete();
        dec_pc.delete();
        dec_data.delete();
        rst_n = 1'b1;
    endtask

    task automatic runUntilIssued(input int n, input int budget);
        int k = 0;
        while (issued.size() < n && k < budget) begin
            applyStimulus(1);
            k++;
        end
        checkOutput("issue_budget", 32'(issued.size()), 32'(n));
    endtask

    task automatic checkFirstDecode(input string tag, input logic [31:0] pc, input logic [31:0] data);
        if (dec_pc.size() == 0) begin
            checkOutput({tag, "_present"}, 32'h0, 32'h1);
        end else begin
            checkOutput({tag, "_pc"}, dec_pc[0], pc);
            checkOutput({tag, "_data"}, dec_data[0], data);
        end
    endtask

    initial begin
        imem_req_ready  = 1'b1;
        rst_n           = 1'b1;
        fetch_en        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
        resp_enable     = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_inst  = 32'h0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_req_valid",  32'(imem_req_valid), 32'h0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("rst_busy",       32'(busy), 32'h0);
        checkOutput("rst_resp_ready", 32'(imem_resp_ready), 32'h0);
        checkOutput("rst_req_addr",   imem_req_addr, 32'h0);
        doReset();
        applyStimulus(1);
        checkOutput("post_rst_resp_ready", 32'(imem_resp_ready), 32'h1);
        checkOutput("post_rst_busy",       32'(s_busy), 32'h0);

        // Streaming: back-to-back addresses, decode sees the image in order
        doReset();
        fetch_en = 1'b1; inst_ready = 1'b1; resp_enable = 1'b1;
        applyStimulus(12);
        checkOutput("stream_issue_count", 32'(issued.size()), 32'd11);
        checkOutput("stream_dec_count",   32'(dec_pc.size()), 32'd9);
        for (int i = 0; i < 6; i++)
            if (issued.size() > i) checkOutput($sformatf("stream_addr%0d", i), issued[i], 32'(i * 4));
        for (int i = 0; i < 4; i++)
            if (dec_pc.size() > i) begin
                checkOutput($sformatf("stream_pc%0d", i), dec_pc[i], 32'(i * 4));
                checkOutput($sformatf("stream_data%0d", i), dec_data[i], image[i]);
            end
        fetch_en = 1'b0;
        applyStimulus(6);
        checkOutput("stream_idle_busy", 32'(s_busy), 32'h0);

        // Decode stalled: credit rule caps requests at the queue depth
        doReset();
        fetch_en = 1'b1; resp_enable = 1'b1;
        applyStimulus(8);
        checkOutput("stall_issue_count", 32'(issued.size()), 32'd4);
        checkOutput("stall_req_valid",   32'(s_req_valid), 32'h0);
        checkOutput("stall_inst_valid",  32'(s_inst_valid), 32'h1);
        inst_ready = 1'b1;
        applyStimulus(8);
        for (int i = 0; i < 4; i++)
            if (dec_pc.size() > i) checkOutput($sformatf("stall_pc%0d", i), dec_pc[i], 32'(i * 4));
        checkOutput("stall_resume_present", 32'(issued.size() > 4), 32'h1);
        if (issued.size() > 4) checkOutput("stall_resume_addr", issued[4], 32'h10);

        // Redirect with three requests in flight
        doReset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        runUntilIssued(3, 10);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        applyStimulus(1);
        checkOutput("redir_req_blocked", 32'(s_req_valid), 32'h0);
        redirect_valid = 1'b0; resp_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("drain_req_valid%0d", i), 32'(s_req_valid), 32'h0);
            checkOutput($sformatf("drain_resp_fire%0d", i), 32'(s_resp_fire), 32'h1);
        end
        checkOutput("drain_no_decode", 32'(dec_pc.size()), 32'h0);
        applyStimulus(4);
        if (issued.size() > 3) checkOutput("redir_addr", issued[3], 32'h100);
        checkFirstDecode("redir_first", 32'h100, 32'hFFFF_FEFF);

        // Redirect in the same cycle a response fires, two in flight
        doReset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        runUntilIssued(2, 10);
        resp_enable = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        applyStimulus(1);
        checkOutput("same_resp_fire", 32'(s_resp_fire), 32'h1);
        redirect_valid = 1'b0;
        applyStimulus(1);
        checkOutput("same_drain_req", 32'(s_req_valid), 32'h0);
        applyStimulus(4);
        if (issued.size() > 2) checkOutput("same_addr", issued[2], 32'h200);
        checkFirstDecode("same_first", 32'h200, 32'hFFFF_FDFF);

        // PC wrap from the top of the address space
        doReset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        applyStimulus(1);
        redirect_valid = 1'b0;
        applyStimulus(1);
        checkOutput("wrap_pc_loaded", s_req_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_idle_busy", 32'(s_busy), 32'h0);
        fetch_en = 1'b1; inst_ready = 1'b1; resp_enable = 1'b1;
        applyStimulus(5);
        checkOutput("wrap_issue_present", 32'(issued.size() >= 2), 32'h1);
        if (issued.size() >= 2) begin
            checkOutput("wrap_addr0", issued[0], 32'hFFFF_FFFC);
            checkOutput("wrap_addr1", issued[1], 32'h0000_0000);
        end
        checkFirstDecode("wrap_first", 32'hFFFF_FFFC, 32'h0000_0003);

        // Reset mid-stream with four requests in flight
        doReset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        runUntilIssued(4, 10);
        applyStimulus(1);
        checkOutput("mid_busy_before", 32'(s_busy), 32'h1);
        checkOutput("mid_credit_stop", 32'(s_req_valid), 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_req_valid",  32'(imem_req_valid), 32'h0);
        checkOutput("mid_rst_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("mid_rst_busy",       32'(busy), 32'h0);
        checkOutput("mid_rst_resp_ready", 32'(imem_resp_ready), 32'h0);
        @(negedge clk);
        doReset();
        applyStimulus(3);
        checkOutput("mid_after_busy",  32'(s_busy), 32'h0);
        checkOutput("mid_after_req",   32'(s_req_valid), 32'h0);
        checkOutput("mid_after_addr",  s_req_addr, 32'h0);
        fetch_en = 1'b1; inst_ready = 1'b1; resp_enable = 1'b1;
        applyStimulus(3);
        checkOutput("mid_restart_present", 32'(issued.size() > 0), 32'h1);
        if (issued.size() > 0) checkOutput("mid_restart_addr", issued[0], 32'h0);
        checkOutput("mid_restart_busy", 32'(s_busy), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
